// File: rtl/cfi_mailbox_slave.sv
// CFI log mailbox: AXI slave holding a payload register file plus doorbell/done/verdict
// handshake registers shared with the root-of-trust through a simple register port.
package ariane_axi;
  typedef logic [3:0]  id_t;
  typedef logic [63:0] addr_t;
  typedef logic [63:0] data_t;
  typedef logic [7:0]  strb_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed { id_t id; addr_t addr; logic [7:0] len; } ax_chan_t;
  typedef struct packed { data_t data; strb_t strb; logic last; } w_chan_t;
  typedef struct packed { id_t id; logic [1:0] resp; } b_chan_t;
  typedef struct packed { id_t id; data_t data; logic [1:0] resp; logic last; } r_chan_t;

  typedef struct packed {
    ax_chan_t aw; logic aw_valid;
    w_chan_t  w;  logic w_valid;
    logic     b_ready;
    ax_chan_t ar; logic ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic aw_ready; logic ar_ready; logic w_ready;
    logic b_valid; b_chan_t b;
    logic r_valid; r_chan_t r;
  } resp_t;
endpackage

module cfi_mailbox_slave #(
  parameter int NR_PAYLOAD_WORDS = 8,
  parameter int OFFSET_WIDTH     = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  ariane_axi::req_t        axi_req_i,
  output ariane_axi::resp_t       axi_rsp_o,
  output logic                    doorbell_irq_o,
  input  logic                    rot_req_i,
  input  logic                    rot_we_i,
  input  logic [OFFSET_WIDTH-1:0] rot_addr_i,
  input  logic [31:0]             rot_wdata_i,
  output logic [31:0]             rot_rdata_o,
  output logic                    rot_rvalid_o
);
  import ariane_axi::*;

  localparam int WORD_W = OFFSET_WIDTH - 2;
  typedef logic [WORD_W-1:0] word_t;
  typedef enum logic [2:0] {SEL_PAYLOAD, SEL_DOORBELL, SEL_DONE, SEL_VERDICT, SEL_NONE} sel_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  logic [31:0] payload [NR_PAYLOAD_WORDS];
  logic        pending, done;
  logic [1:0]  verdict;

  function automatic sel_e decode(word_t word);
    if (int'(word) < NR_PAYLOAD_WORDS) return SEL_PAYLOAD;
    if (int'(word) == 16)              return SEL_DOORBELL;
    if (int'(word) == 17)              return SEL_DONE;
    if (int'(word) == 18)              return SEL_VERDICT;
    return SEL_NONE;
  endfunction

  function automatic logic [31:0] reg_value(word_t word);
    logic [31:0] v;
    v = '0;
    case (decode(word))
      SEL_PAYLOAD:  for (int i = 0; i < NR_PAYLOAD_WORDS; i++) if (int'(word) == i) v = payload[i];
      SEL_DOORBELL: v = {31'd0, pending};
      SEL_DONE:     v = {31'd0, done};
      SEL_VERDICT:  v = {30'd0, verdict};
      default:      v = '0;
    endcase
    return v;
  endfunction

  // Write channel state
  w_state_e    w_state;
  logic        aw_ready_q, w_ready_q, b_valid_q;
  logic [1:0]  b_resp_q;
  id_t         aw_id;
  word_t       aw_word;
  logic [7:0]  aw_len;
  logic [31:0] lane_data;
  logic [3:0]  lane_strb;
  sel_e        w_sel;
  logic [1:0]  w_resp;
  logic        w_fire, pl_we, db_set;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    lane_data = aw_word[0] ? axi_req_i.w.data[63:32] : axi_req_i.w.data[31:0];
    lane_strb = aw_word[0] ? axi_req_i.w.strb[7:4]   : axi_req_i.w.strb[3:0];
    w_sel     = decode(aw_word);
    w_fire    = (w_state == W_DATA) && w_ready_q && axi_req_i.w_valid && axi_req_i.w.last;
    if (w_sel == SEL_NONE)                                w_resp = RESP_DECERR;
    else if (aw_len != 8'd0)                              w_resp = RESP_SLVERR;
    else if (w_sel == SEL_DONE || w_sel == SEL_VERDICT)   w_resp = RESP_SLVERR;
    else if (pending)                                     w_resp = RESP_SLVERR;
    else                                                  w_resp = RESP_OKAY;
    pl_we  = w_fire && (w_resp == RESP_OKAY) && (w_sel == SEL_PAYLOAD);
    db_set = w_fire && (w_resp == RESP_OKAY) && (w_sel == SEL_DOORBELL) && lane_strb[0] && lane_data[0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state    <= W_IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      aw_id      <= '0;
      aw_word    <= '0;
      aw_len     <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (aw_ready_q && axi_req_i.aw_valid) begin
          aw_id      <= axi_req_i.aw.id;
          aw_word    <= axi_req_i.aw.addr[OFFSET_WIDTH-1:2];
          aw_len     <= axi_req_i.aw.len;
          aw_ready_q <= 1'b0;
          w_ready_q  <= 1'b1;
          w_state    <= W_DATA;
        end else begin
          aw_ready_q <= 1'b1;
        end
        W_DATA: if (w_fire) begin
          w_ready_q <= 1'b0;
          b_valid_q <= 1'b1;
          b_resp_q  <= w_resp;
          w_state   <= W_RESP;
        end
        W_RESP: if (axi_req_i.b_ready) begin
          b_valid_q  <= 1'b0;
          aw_ready_q <= 1'b1;
          w_state    <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel state; beat data is taken live from the registers in each beat's cycle.
  r_state_e    r_state;
  logic        ar_ready_q, r_valid_q;
  id_t         ar_id;
  word_t       ar_word;
  logic [7:0]  ar_len, r_cnt;
  logic        r_last;
  logic [1:0]  r_resp;
  logic [31:0] r_word;

  always_comb begin
    r_last = (r_cnt == ar_len);
    if (decode(ar_word) == SEL_NONE) r_resp = RESP_DECERR;
    else if (ar_len != 8'd0)         r_resp = RESP_SLVERR;
    else                             r_resp = RESP_OKAY;
    r_word = (r_valid_q && r_resp == RESP_OKAY) ? reg_value(ar_word) : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= R_IDLE;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      ar_id      <= '0;
      ar_word    <= '0;
      ar_len     <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (ar_ready_q && axi_req_i.ar_valid) begin
          ar_id      <= axi_req_i.ar.id;
          ar_word    <= axi_req_i.ar.addr[OFFSET_WIDTH-1:2];
          ar_len     <= axi_req_i.ar.len;
          r_cnt      <= '0;
          ar_ready_q <= 1'b0;
          r_valid_q  <= 1'b1;
          r_state    <= R_DATA;
        end else begin
          ar_ready_q <= 1'b1;
        end
        R_DATA: if (axi_req_i.r_ready) begin
          if (r_last) begin
            r_valid_q  <= 1'b0;
            ar_ready_q <= 1'b1;
            r_state    <= R_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  word_t rot_word;
  sel_e  rot_sel;
  assign rot_word = rot_addr_i[OFFSET_WIDTH-1:2];
  assign rot_sel  = decode(rot_word);

  // The AXI doorbell set is applied last so it overrides a same-edge RoT DONE write.
  // NOTE: the payload array is reset explicitly because its cleared state is architecturally visible.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NR_PAYLOAD_WORDS; i++) payload[i] <= '0;
      pending <= 1'b0;
      done    <= 1'b0;
      verdict <= '0;
    end else begin
      if (rot_req_i && rot_we_i && rot_sel == SEL_DONE) begin
        done <= rot_wdata_i[0];
        if (rot_wdata_i[0]) pending <= 1'b0;
      end
      if (rot_req_i && rot_we_i && rot_sel == SEL_VERDICT) verdict <= rot_wdata_i[1:0];
      if (db_set) begin
        pending <= 1'b1;
        done    <= 1'b0;
      end
      if (pl_we) begin
        for (int i = 0; i < NR_PAYLOAD_WORDS; i++) begin
          if (int'(aw_word) == i) begin
            for (int b = 0; b < 4; b++) if (lane_strb[b]) payload[i][8*b +: 8] <= lane_data[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rot_rvalid_o <= 1'b0;
      rot_rdata_o  <= '0;
    end else begin
      rot_rvalid_o <= rot_req_i && !rot_we_i;
      if (rot_req_i && !rot_we_i) rot_rdata_o <= reg_value(rot_word);
    end
  end

  assign doorbell_irq_o = pending;

  always_comb begin
    axi_rsp_o          = '0;
    axi_rsp_o.aw_ready = aw_ready_q;
    axi_rsp_o.w_ready  = w_ready_q;
    axi_rsp_o.b_valid  = b_valid_q;
    axi_rsp_o.b.id     = aw_id;
    axi_rsp_o.b.resp   = b_resp_q;
    axi_rsp_o.ar_ready = ar_ready_q;
    axi_rsp_o.r_valid  = r_valid_q;
    axi_rsp_o.r.id     = ar_id;
    axi_rsp_o.r.data   = {r_word, r_word};
    axi_rsp_o.r.resp   = r_resp;
    axi_rsp_o.r.last   = r_last;
  end

  logic unused;
  assign unused = ^{axi_req_i.aw.addr[63:OFFSET_WIDTH], axi_req_i.aw.addr[1:0],
                    axi_req_i.ar.addr[63:OFFSET_WIDTH], axi_req_i.ar.addr[1:0],
                    rot_addr_i[1:0], rot_wdata_i[31:2]};
endmodule

// File: tb/tb_cfi_mailbox_slave.sv
// Scoreboard bench for cfi_mailbox_slave: expected B/R/RoT responses are queued as stimulus
// is driven and compared by negedge monitors when the DUT presents them.
module tb_cfi_mailbox_slave;
  import ariane_axi::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  req_t        req;
  resp_t       rsp;
  logic        irq;
  logic        rot_req, rot_we, rot_rvalid;
  logic [7:0]  rot_addr;
  logic [31:0] rot_wdata, rot_rdata;

  always #5 clk_i = ~clk_i;

  cfi_mailbox_slave #(.NR_PAYLOAD_WORDS(8), .OFFSET_WIDTH(8)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .axi_req_i      (req),
    .axi_rsp_o      (rsp),
    .doorbell_irq_o (irq),
    .rot_req_i      (rot_req),
    .rot_we_i       (rot_we),
    .rot_addr_i     (rot_addr),
    .rot_wdata_i    (rot_wdata),
    .rot_rdata_o    (rot_rdata),
    .rot_rvalid_o   (rot_rvalid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed { id_t id; logic [1:0] resp; } b_exp_t;
  typedef struct packed { id_t id; logic [63:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t      b_q[$];
  r_exp_t      r_q[$];
  logic [31:0] rot_q[$];
  b_exp_t      be;
  r_exp_t      re;
  logic [31:0] rv;
  id_t         next_id = 4'd1;

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (rsp.b_valid && req.b_ready) begin
        if (b_q.size() == 0) check("b_unexpected", 1, 0);
        else begin
          be = b_q.pop_front();
          check("b_resp", rsp.b.resp, be.resp);
          check("b_id", rsp.b.id, be.id);
        end
      end
      if (rsp.r_valid && req.r_ready) begin
        if (r_q.size() == 0) check("r_unexpected", 1, 0);
        else begin
          re = r_q.pop_front();
          check("r_data", rsp.r.data, re.data);
          check("r_resp", rsp.r.resp, re.resp);
          check("r_last", rsp.r.last, re.last);
          check("r_id", rsp.r.id, re.id);
        end
      end
      if (rot_rvalid) begin
        if (rot_q.size() == 0) check("rot_unexpected", 1, 0);
        else begin
          rv = rot_q.pop_front();
          check("rot_rdata", rot_rdata, rv);
        end
      end
    end
  end

  // All tasks start and end one time unit after a rising edge.
  task automatic send_aw(input logic [7:0] off, input logic [7:0] len, input id_t id);
    bit ok = 0;
    req.aw.addr = 64'hC000_0000_0000_0000 | 64'(off);
    req.aw.id = id; req.aw.len = len; req.aw_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin @(negedge clk_i); if (rsp.aw_ready) begin ok = 1; break; end end
    if (!ok) check("aw_timeout", 0, 1);
    @(posedge clk_i); #1 req.aw_valid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
    bit ok = 0;
    req.w.data = data; req.w.strb = strb; req.w.last = last; req.w_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin @(negedge clk_i); if (rsp.w_ready) begin ok = 1; break; end end
    if (!ok) check("w_timeout", 0, 1);
    @(posedge clk_i); #1 req.w_valid = 1'b0;
  endtask

  task automatic send_ar(input logic [7:0] off, input logic [7:0] len, input id_t id);
    bit ok = 0;
    req.ar.addr = 64'hA000_0000_0000_0000 | 64'(off);
    req.ar.id = id; req.ar.len = len; req.ar_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin @(negedge clk_i); if (rsp.ar_ready) begin ok = 1; break; end end
    if (!ok) check("ar_timeout", 0, 1);
    @(posedge clk_i); #1 req.ar_valid = 1'b0;
  endtask

  task automatic collect_b();
    bit ok = 0;
    req.b_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin @(negedge clk_i); #1; if (b_q.size() == 0) begin ok = 1; break; end end
    if (!ok) begin check("b_timeout", 0, 1); b_q.delete(); end
    @(posedge clk_i); #1 req.b_ready = 1'b0;
  endtask

  task automatic collect_r();
    bit ok = 0;
    req.r_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin @(negedge clk_i); #1; if (r_q.size() == 0) begin ok = 1; break; end end
    if (!ok) begin check("r_timeout", 0, 1); r_q.delete(); end
    @(posedge clk_i); #1 req.r_ready = 1'b0;
  endtask

  task automatic axi_write(input logic [7:0] off, input logic [31:0] data, input logic [3:0] strb,
                           input logic [7:0] len, input logic [1:0] exp_resp);
    logic [7:0] strb8;
    strb8 = off[2] ? {strb, 4'h0} : {4'h0, strb};
    b_q.push_back('{id: next_id, resp: exp_resp});
    send_aw(off, len, next_id);
    for (int b = 0; b <= int'(len); b++) send_w({data, data}, strb8, b == int'(len));
    collect_b();
    next_id++;
  endtask

  task automatic axi_read(input logic [7:0] off, input logic [7:0] len, input logic [31:0] exp,
                          input logic [1:0] exp_resp);
    for (int b = 0; b <= int'(len); b++)
      r_q.push_back('{id: next_id, data: (exp_resp == RESP_OKAY) ? {exp, exp} : 64'd0,
                      resp: exp_resp, last: b == int'(len)});
    send_ar(off, len, next_id);
    collect_r();
    next_id++;
  endtask

  task automatic rot_write(input logic [7:0] off, input logic [31:0] data);
    rot_req = 1'b1; rot_we = 1'b1; rot_addr = off; rot_wdata = data;
    @(posedge clk_i); #1 rot_req = 1'b0; rot_we = 1'b0;
  endtask

  task automatic rot_read(input logic [7:0] off, input logic [31:0] exp);
    rot_q.push_back(exp);
    rot_req = 1'b1; rot_we = 1'b0; rot_addr = off;
    @(posedge clk_i); #1 rot_req = 1'b0;
    @(negedge clk_i); #1;
    check("rot_latency", rot_q.size(), 0);
    rot_q.delete();
    @(posedge clk_i); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {rsp.aw_ready, rsp.w_ready, rsp.b_valid, rsp.ar_ready, rsp.r_valid,
                irq, rot_rvalid, rot_rdata}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    req = '0;
    rot_req = 0; rot_we = 0; rot_addr = '0; rot_wdata = '0;
    repeat (3) @(posedge clk_i);
    #1 check_reset_outputs("reset_state");
    @(negedge clk_i) rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;

    // Lane 1 write, replicated read-back, RoT read
    axi_write(8'h04, 32'hDEADBEEF, 4'hF, 8'd0, RESP_OKAY);
    axi_read(8'h04, 8'd0, 32'hDEADBEEF, RESP_OKAY);
    rot_read(8'h04, 32'hDEADBEEF);

    // Byte strobes merge into the existing word
    axi_write(8'h08, 32'hAABBCCDD, 4'h3, 8'd0, RESP_OKAY);
    axi_write(8'h08, 32'h11223344, 4'hC, 8'd0, RESP_OKAY);
    axi_read(8'h08, 8'd0, 32'h1122CCDD, RESP_OKAY);

    // Last payload word and first word past the payload
    axi_write(8'h1C, 32'hCAFEF00D, 4'hF, 8'd0, RESP_OKAY);
    rot_read(8'h1C, 32'hCAFEF00D);
    axi_write(8'h20, 32'h12345678, 4'hF, 8'd0, RESP_DECERR);
    axi_read(8'h20, 8'd0, 32'h0, RESP_DECERR);
    axi_write(8'h00, 32'h11223344, 4'hF, 8'd0, RESP_OKAY);

    // Doorbell, locked payload, RoT completion
    b_q.push_back('{id: next_id, resp: RESP_OKAY});
    send_aw(8'h40, 8'd0, next_id);
    check("irq_before_commit", irq, 0);
    send_w(64'h0000_0001_0000_0001, 8'h0F, 1'b1);
    check("irq_after_commit", irq, 1);
    collect_b();
    next_id++;
    axi_write(8'h00, 32'hAAAAAAAA, 4'hF, 8'd0, RESP_SLVERR);
    axi_write(8'h40, 32'h1, 4'hF, 8'd0, RESP_SLVERR);
    rot_read(8'h00, 32'h11223344);
    rot_write(8'h48, 32'h2);
    rot_write(8'h44, 32'h1);
    check("irq_after_done", irq, 0);
    axi_read(8'h44, 8'd0, 32'h1, RESP_OKAY);
    axi_read(8'h48, 8'd0, 32'h2, RESP_OKAY);
    axi_read(8'h40, 8'd0, 32'h0, RESP_OKAY);
    axi_write(8'h44, 32'h0, 4'hF, 8'd0, RESP_SLVERR);
    rot_read(8'h44, 32'h1);

    // Bursts are rejected
    axi_write(8'h00, 32'h55555555, 4'hF, 8'd3, RESP_SLVERR);
    axi_read(8'h00, 8'd0, 32'h11223344, RESP_OKAY);
    axi_read(8'h00, 8'd1, 32'h0, RESP_SLVERR);

    // Unmapped offset
    axi_write(8'h80, 32'hFFFFFFFF, 4'hF, 8'd0, RESP_DECERR);
    axi_read(8'h80, 8'd0, 32'h0, RESP_DECERR);
    rot_read(8'h80, 32'h0);
    rot_write(8'h80, 32'h3);
    rot_read(8'h48, 32'h2);
    axi_read(8'h04, 8'd0, 32'hDEADBEEF, RESP_OKAY);

    // Same-edge doorbell set and RoT DONE=1: new request wins
    b_q.push_back('{id: next_id, resp: RESP_OKAY});
    send_aw(8'h40, 8'd0, next_id);
    rot_req = 1'b1; rot_we = 1'b1; rot_addr = 8'h44; rot_wdata = 32'h1;
    send_w(64'h0000_0001_0000_0001, 8'h0F, 1'b1);
    rot_req = 1'b0; rot_we = 1'b0;
    collect_b();
    next_id++;
    check("irq_race", irq, 1);
    axi_read(8'h40, 8'd0, 32'h1, RESP_OKAY);
    axi_read(8'h44, 8'd0, 32'h0, RESP_OKAY);

    // Backpressure on B and R, then reset mid-hold
    send_aw(8'h08, 8'd0, 4'hB);
    send_w(64'h1234_5678_1234_5678, 8'h0F, 1'b1);
    send_ar(8'h04, 8'd0, 4'hC);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("hold_bvalid", rsp.b_valid, 1);
      check("hold_bresp", {rsp.b.id, rsp.b.resp}, {4'hB, RESP_SLVERR});
      check("hold_rvalid", rsp.r_valid, 1);
      check("hold_rdata", rsp.r.data, 64'hDEADBEEF_DEADBEEF);
      check("hold_rlast", {rsp.r.id, rsp.r.resp, rsp.r.last}, {4'hC, RESP_OKAY, 1'b1});
    end
    #2 rst_ni = 1'b0;
    #1 check_reset_outputs("reset_mid_hold");
    b_q.delete(); r_q.delete(); rot_q.delete();
    @(negedge clk_i) rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    axi_read(8'h04, 8'd0, 32'h0, RESP_OKAY);
    axi_read(8'h40, 8'd0, 32'h0, RESP_OKAY);
    rot_read(8'h48, 32'h0);
    axi_write(8'h04, 32'h0BADF00D, 4'hF, 8'd0, RESP_OKAY);
    rot_read(8'h04, 32'h0BADF00D);

    repeat (3) @(posedge clk_i);
    #1 check("scoreboard_drained", b_q.size() + r_q.size() + rot_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
